// File: rtl/hilo_ctrl.sv
// HI/LO architectural register controller: tracks xlu operations, commits results, serves mt/mf, raises D-stage stall.
// Optional macro HILO_BYPASS_EN forwards commit/mt data onto mf_data and drops COMMIT from the stall window.
module hilo_ctrl #(
  parameter int MAX_BUSY = 16,
  parameter int CNT_W    = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        md_start,
  input  logic        md_busy,
  input  logic [31:0] md_hi,
  input  logic [31:0] md_lo,
  input  logic        d_md_use,
  input  logic        mt_we,
  input  logic        mt_sel,
  input  logic [31:0] mt_data,
  input  logic        mf_sel,
  output logic [31:0] mf_data,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        md_err
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ARM    = 2'd1;
  localparam logic [1:0] ST_RUN    = 2'd2;
  localparam logic [1:0] ST_COMMIT = 2'd3;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_BUSY);

  logic [1:0]       state_r;
  logic [1:0]       state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_s;
  logic             err_r;
  logic             err_s;
  logic [31:0]      hi_r;
  logic [31:0]      lo_r;
  logic [31:0]      hi_s;
  logic [31:0]      lo_s;
  logic [31:0]      commit_hi_s;
  logic [31:0]      commit_lo_s;
  logic             pending_s;
  logic             in_commit_s;

  assign in_commit_s = (state_r == ST_COMMIT);

  // Operation tracking FSM, busy-cycle counter and watchdog next-state
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    err_s   = err_r;
    case (state_r)
      ST_IDLE: begin
        cnt_s = CNT_ZERO;
        if (md_start) begin
          state_s = ST_ARM;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ARM: begin
        if (md_busy) begin
          state_s = ST_RUN;
          cnt_s   = CNT_ONE;
        end else begin
          state_s = ST_COMMIT;
          cnt_s   = CNT_ZERO;
        end
      end
      ST_RUN: begin
        if (!md_busy) begin
          state_s = ST_COMMIT;
          cnt_s   = CNT_ZERO;
        end else if (cnt_r == CNT_MAX) begin
          // Watchdog abort: drop the result, leave HI/LO untouched
          state_s = ST_IDLE;
          cnt_s   = CNT_ZERO;
          err_s   = 1'b1;
        end else begin
          state_s = ST_RUN;
          cnt_s   = cnt_r + CNT_ONE;
        end
      end
      ST_COMMIT: begin
        cnt_s = CNT_ZERO;
        if (md_start) begin
          state_s = ST_ARM;
        end else begin
          state_s = ST_IDLE;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = CNT_ZERO;
      end
    endcase
  end

  // HI/LO next values: commit first, then the younger mt write overrides its register
  always_comb begin
    commit_hi_s = hi_r;
    commit_lo_s = lo_r;
    if (in_commit_s) begin
      commit_hi_s = md_hi;
      commit_lo_s = md_lo;
    end else begin
      commit_hi_s = hi_r;
      commit_lo_s = lo_r;
    end
    hi_s = (mt_we && !mt_sel) ? mt_data : commit_hi_s;
    lo_s = (mt_we &&  mt_sel) ? mt_data : commit_lo_s;
  end

  // State and architectural register update
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= CNT_ZERO;
      err_r   <= 1'b0;
      hi_r    <= 32'h0000_0000;
      lo_r    <= 32'h0000_0000;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      err_r   <= err_s;
      hi_r    <= hi_s;
      lo_r    <= lo_s;
    end
  end

`ifdef HILO_BYPASS_EN
  assign pending_s = md_start | (state_r == ST_ARM) | (state_r == ST_RUN);

  // Read path with mt forward taking priority over the commit forward
  always_comb begin
    mf_data = mf_sel ? lo_r : hi_r;
    if (mt_we && (mt_sel == mf_sel)) begin
      mf_data = mt_data;
    end else if (in_commit_s) begin
      mf_data = mf_sel ? md_lo : md_hi;
    end else begin
      mf_data = mf_sel ? lo_r : hi_r;
    end
  end
`else
  assign pending_s = md_start | (state_r != ST_IDLE);

  assign mf_data = mf_sel ? lo_r : hi_r;
`endif

  // Reset gates stall so it drops immediately even if md_start is asserted
  assign stall  = d_md_use & pending_s & ~reset;
  assign hi     = hi_r;
  assign lo     = lo_r;
  assign md_err = err_r;

endmodule
